// File: rtl/mem_master.sv
// Burst memory master: fill-writes or reads 1..8 consecutive addresses, wrapping at 2^AW.
// Optional read-back check of every written byte is enabled with `define MEM_MASTER_VERIFY_EN.
module mem_master #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 8
) (
  input  logic          CLK,
  input  logic          R,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [2:0]    req_len,
  input  logic [DW-1:0] req_data,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data,
  output logic [AW-1:0] rsp_addr,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] mem_A,
  output logic [DW-1:0] mem_D,
  output logic          mem_WE,
  output logic          mem_RE,
  input  logic [DW-1:0] mem_out
);

`ifdef MEM_MASTER_VERIFY_EN
  typedef enum logic [1:0] {StIdle, StWrite, StRead, StVerify} state_e;
`else
  typedef enum logic [1:0] {StIdle, StWrite, StRead} state_e;
`endif

  localparam logic [AW-1:0] AddrOne = AW'(1);

  state_e        r_state, w_state;
  logic [2:0]    r_cnt, w_cnt;
  logic [2:0]    r_len, w_len;
  logic [AW-1:0] r_mem_a, w_mem_a;
  logic [DW-1:0] r_mem_d, w_mem_d;
  logic          r_we, w_we;
  logic          r_re, w_re;
  logic          r_ready, w_ready;
  logic          r_done, w_done;
  logic          r_rsp_valid, w_rsp_valid;
  logic [DW-1:0] r_rsp_data, w_rsp_data;
  logic [AW-1:0] r_rsp_addr, w_rsp_addr;
  logic          w_last;
`ifdef MEM_MASTER_VERIFY_EN
  logic          r_err, w_err;
`endif

  assign w_last = (r_cnt == r_len);

  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_len       = r_len;
    w_mem_a     = r_mem_a;
    w_mem_d     = r_mem_d;
    w_we        = 1'b0;
    w_re        = 1'b0;
    w_ready     = 1'b0;
    w_done      = 1'b0;
    w_rsp_valid = 1'b0;
    w_rsp_data  = r_rsp_data;
    w_rsp_addr  = r_rsp_addr;
`ifdef MEM_MASTER_VERIFY_EN
    w_err       = r_err;
`endif
    unique case (r_state)
      StIdle: begin
        w_ready = 1'b1;
        if (req_valid) begin
          w_ready = 1'b0;
          w_len   = req_len;
          w_cnt   = 3'd0;
          w_mem_a = req_addr;
`ifdef MEM_MASTER_VERIFY_EN
          w_err   = 1'b0;
`endif
          if (req_we) begin
            w_state = StWrite;
            w_we    = 1'b1;
            w_mem_d = req_data;
          end else begin
            w_state = StRead;
            w_re    = 1'b1;
          end
        end
      end
`ifdef MEM_MASTER_VERIFY_EN
      StWrite: begin
        // Read the just-written address back in the following cycle.
        w_state = StVerify;
        w_re    = 1'b1;
      end
      StVerify: begin
        if (mem_out != r_mem_d) w_err = 1'b1;
        if (w_last) begin
          w_state = StIdle;
          w_done  = 1'b1;
          w_ready = 1'b1;
        end else begin
          w_state = StWrite;
          w_cnt   = r_cnt + 3'd1;
          w_mem_a = r_mem_a + AddrOne;
          w_we    = 1'b1;
        end
      end
`else
      StWrite: begin
        if (w_last) begin
          w_state = StIdle;
          w_done  = 1'b1;
          w_ready = 1'b1;
        end else begin
          w_cnt   = r_cnt + 3'd1;
          w_mem_a = r_mem_a + AddrOne;
          w_we    = 1'b1;
        end
      end
`endif
      StRead: begin
        w_rsp_valid = 1'b1;
        w_rsp_data  = mem_out;
        w_rsp_addr  = r_mem_a;
        if (w_last) begin
          w_state = StIdle;
          w_done  = 1'b1;
          w_ready = 1'b1;
        end else begin
          w_cnt   = r_cnt + 3'd1;
          w_mem_a = r_mem_a + AddrOne;
          w_re    = 1'b1;
        end
      end
      default: begin
        w_state = StIdle;
        w_ready = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge R) begin
    if (R) begin
      r_state     <= StIdle;
      r_cnt       <= 3'd0;
      r_len       <= 3'd0;
      r_mem_a     <= '0;
      r_mem_d     <= '0;
      r_we        <= 1'b0;
      r_re        <= 1'b0;
      r_ready     <= 1'b1;
      r_done      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_addr  <= '0;
`ifdef MEM_MASTER_VERIFY_EN
      r_err       <= 1'b0;
`endif
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_len       <= w_len;
      r_mem_a     <= w_mem_a;
      r_mem_d     <= w_mem_d;
      r_we        <= w_we;
      r_re        <= w_re;
      r_ready     <= w_ready;
      r_done      <= w_done;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_data  <= w_rsp_data;
      r_rsp_addr  <= w_rsp_addr;
`ifdef MEM_MASTER_VERIFY_EN
      r_err       <= w_err;
`endif
    end
  end

  assign req_ready = r_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_addr  = r_rsp_addr;
  assign done      = r_done;
  assign mem_A     = r_mem_a;
  assign mem_D     = r_mem_d;
  assign mem_WE    = r_we;
  assign mem_RE    = r_re;
`ifdef MEM_MASTER_VERIFY_EN
  assign err       = r_err;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_master.sv
// Directed bench for mem_master with a 32-byte behavioural memory.
// Write-beat timing adapts to MEM_MASTER_VERIFY_EN; the corrupt-read-back case runs only with it.
module tb_mem_master;
  logic       CLK = 1'b0;
  logic       R = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_we = 1'b0;
  logic [4:0] req_addr = '0;
  logic [2:0] req_len = '0;
  logic [7:0] req_data = '0;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic [4:0] rsp_addr;
  logic       done;
  logic       err;
  logic [4:0] mem_A;
  logic [7:0] mem_D;
  logic       mem_WE;
  logic       mem_RE;
  logic [7:0] mem_out;

  logic [7:0] mem [32];
  logic       corrupt = 1'b0;
  int         n_cmp = 0;
  int         n_err = 0;

  mem_master #(.AW(5), .DW(8)) dut (
    .CLK(CLK), .R(R), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len), .req_data(req_data), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_addr(rsp_addr), .done(done), .err(err), .mem_A(mem_A),
    .mem_D(mem_D), .mem_WE(mem_WE), .mem_RE(mem_RE), .mem_out(mem_out)
  );

  always #5 CLK = ~CLK;

  // Memory stores the inverse at address 3 while corrupt is set.
  always @(posedge CLK) begin
    if (mem_WE) mem[mem_A] = (corrupt && mem_A == 5'd3) ? ~mem_D : mem_D;
  end
  assign mem_out = mem_RE ? mem[mem_A] : 8'h00;

  function automatic logic [7:0] pat(input int a);
    pat = 8'(a) ^ 8'hA0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Checks one write beat (and its read-back cycle when enabled), leaving time at the next cycle.
  task automatic write_beat(input logic [4:0] a, input logic [7:0] d);
    check("wr_we", mem_WE, 1);
    check("wr_re", mem_RE, 0);
    check("wr_addr", mem_A, a);
    check("wr_data", mem_D, d);
    check("wr_ready", req_ready, 0);
    tick();
`ifdef MEM_MASTER_VERIFY_EN
    check("vf_re", mem_RE, 1);
    check("vf_we", mem_WE, 0);
    check("vf_addr", mem_A, a);
    tick();
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = pat(i);

    // Asynchronous reset, observed before any clock edge.
    #1 R = 1'b1;
    #1;
    check("rst_ready", req_ready, 1);
    check("rst_we", mem_WE, 0);
    check("rst_re", mem_RE, 0);
    check("rst_a", mem_A, 0);
    check("rst_d", mem_D, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_addr", rsp_addr, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);

    // Write fill 0x25 at 29, len 3, request present at the first edge after reset.
    #10;
    R = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 5'd29; req_len = 3'd3; req_data = 8'h25;
    tick();
    req_valid = 1'b0;
    write_beat(5'd29, 8'h25);
    write_beat(5'd30, 8'h25);
    write_beat(5'd31, 8'h25);
    write_beat(5'd0, 8'h25);
    check("wr_done", done, 1);
    check("wr_done_ready", req_ready, 1);
    check("wr_end_we", mem_WE, 0);
    check("wr_end_a_hold", mem_A, 0);
    check("mem29", mem[29], 8'h25);
    check("mem30", mem[30], 8'h25);
    check("mem31", mem[31], 8'h25);
    check("mem0", mem[0], 8'h25);
    check("mem1_untouched", mem[1], pat(1));

    // Read back the same four addresses; request presented in the done cycle.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd29; req_len = 3'd3;
    tick();
    req_valid = 1'b0;
    check("rd_beat0_re", mem_RE, 1);
    check("rd_beat0_a", mem_A, 29);
    check("rd_beat0_no_rsp", rsp_valid, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rd_rsp_valid", rsp_valid, 1);
      check("rd_rsp_data", rsp_data, 8'h25);
      check("rd_rsp_addr", rsp_addr, (29 + i) % 32);
      check("rd_done", done, (i == 3) ? 1 : 0);
    end
    tick();
    check("rd_after_rsp", rsp_valid, 0);
    check("rd_after_done", done, 0);

    // len 7 read at 0 with req_valid held: the second request waits for the done cycle.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd0; req_len = 3'd7;
    tick();
    for (int k = 0; k < 8; k++) begin
      check("hold_ready_low", req_ready, 0);
      check("hold_re", mem_RE, 1);
      if (k > 0) check("hold_rsp_data", rsp_data, (k == 1) ? 8'h25 : pat(k - 1));
      tick();
    end
    check("hold_done", done, 1);
    check("hold_ready_hi", req_ready, 1);
    check("hold_last_rsp", rsp_data, pat(7));
    tick();
    req_valid = 1'b0;
    check("hold_accept2_ready", req_ready, 0);
    check("hold_accept2_re", mem_RE, 1);
    check("hold_accept2_a", mem_A, 0);
    check("hold_accept2_done", done, 0);
    for (int k = 0; k < 20; k++) begin
      if (done) break;
      tick();
    end
    check("hold_second_done", done, 1);
    tick();

    // Reset during beat 2 of a len 7 write of 0x18 at 8.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 5'd8; req_len = 3'd7; req_data = 8'h18;
    tick();
    req_valid = 1'b0;
    write_beat(5'd8, 8'h18);
    write_beat(5'd9, 8'h18);
    check("abort_beat2_we", mem_WE, 1);
    check("abort_beat2_a", mem_A, 10);
    R = 1'b1;
    #1;
    check("abort_we", mem_WE, 0);
    check("abort_a", mem_A, 0);
    check("abort_ready", req_ready, 1);
    tick();
    R = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("abort_no_done", done, 0);
      check("abort_no_we", mem_WE, 0);
    end
    check("abort_mem8", mem[8], 8'h18);
    check("abort_mem9", mem[9], 8'h18);
    check("abort_mem10", mem[10], pat(10));
    check("abort_err", err, 0);

`ifdef MEM_MASTER_VERIFY_EN
    // Corrupted read-back at address 3 raises a sticky err.
    corrupt = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 5'd2; req_len = 3'd2; req_data = 8'h15;
    tick();
    req_valid = 1'b0;
    write_beat(5'd2, 8'h15);
    check("vf_err_clean", err, 0);
    write_beat(5'd3, 8'h15);
    check("vf_err_set", err, 1);
    write_beat(5'd4, 8'h15);
    check("vf_done", done, 1);
    check("vf_err_at_done", err, 1);
    corrupt = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd2; req_len = 3'd0;
    tick();
    req_valid = 1'b0;
    check("vf_err_cleared", err, 0);
    tick();
    check("vf_rd_data", rsp_data, 8'h15);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_master.md
MEM_MASTER -- requirements
Module: mem_master

Interface
REQ-001 Parameter AW, default 5: memory address width (32-byte memory).
REQ-002 Parameter DW, default 8: memory data width.
REQ-003 Port CLK  input  1: single clock; all state changes on rising edge.
REQ-004 Port R  input  1: reset, asynchronous, active-high.
REQ-005 Port req_valid  input  1: request present.
REQ-006 Port req_ready  output  1: block can accept a request; high only in IDLE.
REQ-007 Port req_we  input  1: 1 = write (fill) burst, 0 = read burst.
REQ-008 Port req_addr  input  AW: burst start address.
REQ-009 Port req_len  input  3: burst length minus one (0..7 gives 1..8 beats).
REQ-010 Port req_data  input  DW: fill byte written on every write beat.
REQ-011 Port rsp_valid  output  1: one-cycle pulse per read beat.
REQ-012 Port rsp_data  output  DW: captured read byte, valid while rsp_valid.
REQ-013 Port rsp_addr  output  AW: address of rsp_data.
REQ-014 Port done  output  1: one-cycle pulse after the last beat of any burst.
REQ-015 Port err  output  1: sticky read-back mismatch flag (Configuration).
REQ-016 Port mem_A  output  AW: memory address.
REQ-017 Port mem_D  output  DW: memory write data.
REQ-018 Port mem_WE  output  1: memory write enable; memory writes on rising CLK while high.
REQ-019 Port mem_RE  output  1: memory read enable; memory drives mem_out combinationally while high.
REQ-020 Port mem_out  input  DW: memory read data.

Function
REQ-021 States: IDLE, WRITE, READ, plus VERIFY when configured; all outputs registered.
REQ-022 Accept: at a rising edge with state IDLE and req_valid=1: latch we/addr/len/data, clear err, go to WRITE (req_we=1) or READ (req_we=0); req_ready=0 from the next cycle.
REQ-023 Beat i (i=0..len) occupies exactly one clock cycle, address = (req_addr+i) mod 2^AW; wrap 31->0 with no error.
REQ-024 WRITE beat: mem_WE=1, mem_RE=0, mem_A=beat address, mem_D=req_data.
REQ-025 READ beat: mem_RE=1, mem_WE=0, mem_A=beat address; mem_out sampled at the edge ending the beat; rsp_valid=1, rsp_data=sample, rsp_addr=beat address during the following cycle.
REQ-026 Read latency: beat 0 starts the cycle after accept; first rsp_valid 2 cycles after accept; consecutive beats give consecutive rsp_valid pulses.
REQ-027 No response backpressure; the consumer must take each rsp_valid pulse.
REQ-028 After the last beat: state IDLE, mem_WE=mem_RE=0, done=1 for one cycle, req_ready=1 in that same cycle.
REQ-029 req_valid while req_ready=0 is ignored; the requester holds it until accepted.
REQ-030 Outside beats: mem_WE=0, mem_RE=0; mem_A and mem_D hold last value.

Reset
REQ-031 R=1 immediately (no clock) forces IDLE, req_ready=1, mem_WE=0, mem_RE=0, mem_A=0, mem_D=0, rsp_valid=0, rsp_data=0, rsp_addr=0, done=0, err=0.
REQ-032 R mid-burst aborts it: no further beats, no done, no rsp_valid; memory contents already written stay.
REQ-033 A request with req_valid=1 at the first edge after R deasserts is accepted normally.

Configuration
REQ-034 Macro MEM_MASTER_VERIFY_EN defined: each WRITE beat is followed by one VERIFY cycle (mem_RE=1, same address); if mem_out differs from req_data, err=1 from the next cycle until reset or next accept; write burst takes 2*(len+1) cycles; no rsp_valid for VERIFY.
REQ-035 Macro undefined: no VERIFY state, err tied 0, write burst takes len+1 cycles.

Verification
REQ-036 Write addr=5'd29, len=3, data=8'h25 -> mem_WE high 4 cycles at A=29,30,31,0; done 1 cycle later; memory holds 8'h25 at all four.
REQ-037 Read addr=5'd29, len=3 after REQ-036 -> 4 consecutive rsp_valid pulses, rsp_data=8'h25, rsp_addr=29,30,31,0; first pulse 2 cycles after accept.
REQ-038 req_valid held high during a len=7 read -> req_ready=0 for 8 beat cycles, second request accepted only at the edge where done=1.
REQ-039 R asserted at beat 2 of a len=7 write of 8'h18 at 5'd8 -> mem_WE=0 at once, no done; addresses 8,9 hold 8'h18, address 10 unchanged.
REQ-040 With MEM_MASTER_VERIFY_EN, memory model corrupting address 5'd3 on write of 8'h15 at addr=2, len=2 -> err=1 after VERIFY of address 3, stays high through done; cleared by next accept.
